pwm_ramp_ctrl: RTL and testbench
================================

PWM_RAMP_CTRL -- requirements
Module: pwm_ramp_ctrl

Interface
REQ-001: Parameter PWM_RESOLUTION, default 8, sets the duty and period-counter width in bits.
REQ-002: Parameter STEP_DIV, default 4, sets the number of PWM periods per duty step; legal range is 1..255.
REQ-003: clk  input  1  system clock; all state updates on the rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: req_valid  input  1  a new target duty is offered.
REQ-006: req_duty  input  PWM_RESOLUTION  target duty value, sampled on acceptance.
REQ-007: req_ready  output  1  the block can accept a request.
REQ-008: stop  input  1  abort request; takes priority over everything except rst.
REQ-009: duty_out  output  PWM_RESOLUTION  registered duty value driving the PWM generator.
REQ-010: period_start  output  1  high while the internal period counter equals 0.
REQ-011: busy  output  1  a ramp or soft stop is in progress.
REQ-012: done  output  1  one-cycle pulse when duty_out reaches the target.

Function
REQ-013: A free-running period_cnt of PWM_RESOLUTION bits shall increment every clock and wrap from 2^PWM_RESOLUTION-1 to 0; only rst clears it.
REQ-014: The states shall be IDLE, RAMP and SOFTSTOP; SOFTSTOP exists only with the macro.
REQ-015: req_ready shall equal (state==IDLE) && !stop, combinationally.
REQ-016: A request is accepted when req_valid && req_ready; on acceptance, req_duty is latched into target and the step counter clears to 0.
REQ-017: On acceptance with req_duty==duty_out, the block shall stay in IDLE and pulse done on the next cycle; busy stays 0.
REQ-018: On acceptance with req_duty!=duty_out, the state shall move to RAMP on the next edge with busy=1.
REQ-019: In RAMP, each period_start cycle shall increment the step counter; when the counter reaches STEP_DIV-1, it clears and duty_out moves by exactly 1 toward target on that edge.
REQ-020: The first step shall therefore occur on the STEP_DIV-th period_start after acceptance; duty_out changes only on edges where period_start=1.
REQ-021: When a step makes duty_out equal to target, on the next cycle the state shall be IDLE, busy=0 and done=1 for exactly one cycle.
REQ-022: duty_out shall never wrap or overshoot target; values stay within 0..2^PWM_RESOLUTION-1.
REQ-023: While not in IDLE, req_valid shall be ignored; the request is held by the requester until req_ready is 1.
REQ-024: If stop and req_valid are both high in the same cycle, stop shall win and the request shall not be accepted.
REQ-025: busy shall equal (state!=IDLE).

Reset
REQ-026: While rst=1, the outputs shall be: duty_out=0, target=0, period_cnt=0, step counter=0, state=IDLE, busy=0, done=0.
REQ-027: req_ready shall follow REQ-015 during reset.
REQ-028: period_start shall be 1 during reset and in the first cycle after release.
REQ-029: Reset asserted mid-ramp shall abandon the ramp immediately, with no done pulse.

Configuration
REQ-030: The macro PWM_RAMP_SOFTSTOP_EN selects the stop behaviour.
REQ-031: Without the macro, stop=1 shall set duty_out=0, target=0 and state=IDLE on the next edge, with no done pulse.
REQ-032: With the macro, stop=1 with duty_out!=0 shall set target=0, clear the step counter and enter SOFTSTOP.
REQ-033: SOFTSTOP shall ramp down under the REQ-019/REQ-020 timing, then return to IDLE with done pulsed once.
REQ-034: With the macro, stop=1 with duty_out==0 shall go straight to IDLE with no done pulse.
REQ-035: With the macro, stop re-asserted during SOFTSTOP shall have no additional effect.

Verification
REQ-036: Reset check, with PWM_RESOLUTION=8, rst held 5 cycles -> duty_out=0, busy=0, done=0, req_ready=1, and period_start high in the first cycle after release, then every 256 cycles.
REQ-037: Up-ramp, STEP_DIV=1, request 4 from 0 -> duty_out steps 1,2,3,4 on four consecutive period_start edges; one done pulse; busy high for about 1024 cycles.
REQ-038: Down-ramp, STEP_DIV=2, request 1 from 4 -> three steps spaced 512 cycles apart; done pulses once; req_ready=0 throughout.
REQ-039: Same-value request, request 4 at duty 4 -> done high one cycle later; busy never asserts.
REQ-040: Request while busy, then stop with req_valid in the same cycle -> the held request is ignored until IDLE; in the stop cycle req_ready=0 and the request is not accepted.
REQ-041: Stop at duty 2 mid-ramp -> without the macro, duty_out=0 on the next edge with no done pulse; with the macro, duty_out goes 2->1->0 on step ticks, then one done pulse.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp controller: slews duty_out one LSB per STEP_DIV PWM periods toward a requested target.
// Optional soft stop (ramp down to 0 instead of immediate clear) enabled by PWM_RAMP_SOFTSTOP_EN.
module pwm_ramp_ctrl #(
  parameter int PWM_RESOLUTION = 8,
  parameter int STEP_DIV       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  input  logic [PWM_RESOLUTION-1:0] req_duty,
  output logic                      req_ready,
  input  logic                      stop,
  output logic [PWM_RESOLUTION-1:0] duty_out,
  output logic                      period_start,
  output logic                      busy,
  output logic                      done
);

  localparam logic [7:0] STEP_LAST = 8'(STEP_DIV - 1);

  // state    | meaning
  // IDLE     | holding duty_out, accepting requests
  // RAMP     | stepping duty_out toward target
  // SOFTSTOP | stepping duty_out down to 0 after stop (macro build only)
`ifdef PWM_RAMP_SOFTSTOP_EN
  typedef enum logic [1:0] {IDLE, RAMP, SOFTSTOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

  state_t                      state_q, state_d;
  logic [PWM_RESOLUTION-1:0]   duty_q, duty_d;
  logic [PWM_RESOLUTION-1:0]   target_q, target_d;
  logic [PWM_RESOLUTION-1:0]   period_cnt_q, period_cnt_d;
  logic [7:0]                  step_q, step_d;
  logic                        done_q, done_d;
  logic [PWM_RESOLUTION-1:0]   duty_stepped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      target_q     <= '0;
      period_cnt_q <= '0;
      step_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      target_q     <= target_d;
      period_cnt_q <= period_cnt_d;
      step_q       <= step_d;
      done_q       <= done_d;
    end
  end

  assign period_start = (period_cnt_q == '0);
  assign req_ready    = (state_q == IDLE) && !stop;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign duty_out     = duty_q;

  // Saturating single-LSB move toward target; never wraps past it.
  always_comb begin
    duty_stepped = duty_q;
    if (duty_q < target_q)      duty_stepped = duty_q + 1'b1;
    else if (duty_q > target_q) duty_stepped = duty_q - 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    duty_d       = duty_q;
    target_d     = target_q;
    step_d       = step_q;
    done_d       = 1'b0;
    period_cnt_d = period_cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          target_d = req_duty;
          step_d   = '0;
          if (req_duty == duty_q) done_d  = 1'b1;
          else                    state_d = RAMP;
        end
      end
      default: begin
        if (period_start) begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            duty_d = duty_stepped;
            if (duty_stepped == target_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            step_d = step_q + 8'd1;
          end
        end
      end
    endcase

    // Stop overrides any ramp or acceptance decided above.
`ifdef PWM_RAMP_SOFTSTOP_EN
    if (stop && (state_q != SOFTSTOP)) begin
      target_d = '0;
      step_d   = '0;
      done_d   = 1'b0;
      duty_d   = duty_q;
      if (duty_q != '0) state_d = SOFTSTOP;
      else              state_d = IDLE;
    end
`else
    if (stop) begin
      duty_d   = '0;
      target_d = '0;
      step_d   = '0;
      done_d   = 1'b0;
      state_d  = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Randomized bench for pwm_ramp_ctrl (default build, stop clears immediately) against a
// period-counting reference model.
module tb_pwm_ramp_ctrl;
  localparam int W   = 8;
  localparam int SD  = 2;
  localparam int PER = 256;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic [W-1:0] req_duty;
  logic         req_ready;
  logic         stop;
  logic [W-1:0] duty_out;
  logic         period_start;
  logic         busy;
  logic         done;

  pwm_ramp_ctrl #(.PWM_RESOLUTION(W), .STEP_DIV(SD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_duty(req_duty),
    .req_ready(req_ready), .stop(stop), .duty_out(duty_out),
    .period_start(period_start), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Model: cycle index since reset release, duty, target, ramp start point and
  // number of period starts seen since the ramp began.
  int m_cyc, m_duty, m_tgt, m_s0, m_ps;
  bit m_busy, m_done;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_cyc = 0; m_duty = 0; m_tgt = 0; m_s0 = 0; m_ps = 0;
    m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; req_valid = 1'b0; stop = 1'b0; req_duty = '0;
    for (int i = 0; i < n; i++) begin
      #1;
      check_val("rst_duty", duty_out, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_ready", req_ready, 1);
      check_val("rst_pstart", period_start, 1);
      @(negedge clk);
    end
    rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive inputs, check outputs vs model, advance model across the edge.
  task automatic cyc(input bit v, input int d, input bit s);
    bit ps;
    int mag, dir, nst;
    req_valid = v; req_duty = d[W-1:0]; stop = s;
    #1;
    ps = ((m_cyc % PER) == 0);
    check_val("req_ready", req_ready, int'(!m_busy && !s));
    check_val("duty_out", duty_out, m_duty);
    check_val("busy", busy, int'(m_busy));
    check_val("done", done, int'(m_done));
    check_val("period_start", period_start, int'(ps));
    m_done = 1'b0;
    if (s) begin
      m_duty = 0; m_tgt = 0; m_busy = 1'b0;
    end else if (!m_busy) begin
      if (v) begin
        m_tgt = d;
        if (d == m_duty) m_done = 1'b1;
        else begin m_busy = 1'b1; m_s0 = m_duty; m_ps = 0; end
      end
    end else if (ps) begin
      m_ps++;
      mag = (m_tgt > m_s0) ? m_tgt - m_s0 : m_s0 - m_tgt;
      dir = (m_tgt > m_s0) ? 1 : -1;
      nst = m_ps / SD;
      if (nst > mag) nst = mag;
      m_duty = m_s0 + dir * nst;
      if (m_duty == m_tgt) begin m_busy = 1'b0; m_done = 1'b1; end
    end
    m_cyc++;
    @(negedge clk);
  endtask

  task automatic run_idle(input int budget);
    int k = 0;
    while ((m_busy || m_done) && k < budget) begin
      cyc(1'b0, 0, 1'b0);
      k++;
    end
    check_val("ramp_finished", busy, 0);
  endtask

  localparam int BUDGET = PER * SD * 8 + 600;

  initial begin
    int k, t, t2, mode, n;
    model_reset();
    @(negedge clk);
    do_reset(5);

    // Up-ramp 0 -> 4, then same-value request, then down-ramp 4 -> 1.
    cyc(1'b1, 4, 1'b0);
    run_idle(BUDGET);
    cyc(1'b1, 4, 1'b0);
    cyc(1'b0, 0, 1'b0);
    run_idle(BUDGET);
    cyc(1'b1, 1, 1'b0);
    run_idle(BUDGET);

    // Request held while busy, then stop together with req_valid.
    cyc(1'b1, 3, 1'b0);
    repeat (300) cyc(1'b1, 2, 1'b0);
    cyc(1'b1, 2, 1'b1);
    cyc(1'b1, 2, 1'b0);
    run_idle(BUDGET);

    // Clear, ramp toward 5, stop once duty reaches 2.
    cyc(1'b0, 0, 1'b1);
    cyc(1'b1, 5, 1'b0);
    k = 0;
    while (m_duty != 2 && k < BUDGET) begin cyc(1'b0, 0, 1'b0); k++; end
    check_val("reached_2", duty_out, 2);
    cyc(1'b0, 0, 1'b1);
    repeat (4) cyc(1'b0, 0, 1'b0);

    // Reset in the middle of a ramp.
    cyc(1'b1, 3, 1'b0);
    repeat (400) cyc(1'b0, 0, 1'b0);
    do_reset(2);
    repeat (3) cyc(1'b0, 0, 1'b0);

    for (int it = 0; it < 16; it++) begin
      t = m_duty + int'($urandom_range(0, 6)) - 3;
      if (t < 0) t = 0;
      if (t > PER - 1) t = PER - 1;
      mode = int'($urandom_range(0, 3));
      cyc(1'b1, t, 1'b0);
      case (mode)
        0: run_idle(BUDGET);
        1: begin
          n = int'($urandom_range(0, 1500));
          repeat (n) cyc(1'b0, 0, 1'b0);
          cyc(int'($urandom_range(0, 1)) == 1, int'($urandom_range(0, 255)), 1'b1);
          repeat (3) cyc(1'b0, 0, 1'b0);
        end
        2: begin
          t2 = t + int'($urandom_range(0, 4)) - 2;
          if (t2 < 0) t2 = 0;
          if (t2 > PER - 1) t2 = PER - 1;
          k = 0;
          while (m_busy && k < BUDGET) begin cyc(1'b1, t2, 1'b0); k++; end
          cyc(1'b1, t2, 1'b0);
          run_idle(BUDGET);
        end
        default: begin
          n = int'($urandom_range(1, 900));
          repeat (n) cyc(1'b0, 0, 1'b0);
          do_reset(int'($urandom_range(1, 3)));
          repeat (2) cyc(1'b0, 0, 1'b0);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
